// File: rtl/alu_seq_unit.sv
// ---------------------------------------------------------------------------
// alu_seq_unit
//   Single-request sequential ALU. A request (A, B, Ctrl) is captured when
//   in_valid && in_ready. Simple opcodes produce a result in one cycle; MUL
//   (when built in) runs a 32-step shift-add multiplier first. The result is
//   held in HOLD until the consumer takes it with out_ready, after which the
//   block returns to IDLE and can accept the next request.
//
//   Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL,
//            8 SLT (signed). Anything else -> Y=0, zero=1, err=1.
//
//   Build option:
//     ALU_SEQ_UNIT_MUL_EN  defined   -> opcode 7 is a 32-cycle unsigned MUL
//                          undefined -> no EXEC state / multiplier, opcode 7
//                                       is reported as illegal
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request valid
//   in_ready   out  block idle, request will be taken this edge
//   A, B       in   32-bit operands
//   Ctrl       in   5-bit opcode
//   out_valid  out  result presented
//   out_ready  in   consumer takes the result this edge
//   Y          out  32-bit result
//   zero       out  Y == 0 for the presented result
//   err        out  opcode was illegal or not built in
// ---------------------------------------------------------------------------
module alu_seq_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  Ctrl,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Y,
    output logic        zero,
    output logic        err
);

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4;
    localparam logic [4:0] OP_SLL = 5'd5;
    localparam logic [4:0] OP_SRL = 5'd6;
`ifdef ALU_SEQ_UNIT_MUL_EN
    localparam logic [4:0] OP_MUL = 5'd7;
`endif
    localparam logic [4:0] OP_SLT = 5'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef ALU_SEQ_UNIT_MUL_EN
        EXEC = 2'd1,
`endif
        HOLD = 2'd2
    } state_t;

    // Registered result as presented on the output port.
    typedef struct packed {
        logic [31:0] y;
        logic        zero;
        logic        err;
    } res_t;

    state_t state, state_nxt;
    res_t   res_q;

    logic        accept;
    logic [31:0] alu_y;
    logic        alu_err;
    logic        is_mul;

    assign accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Single-cycle operations, evaluated directly on the request inputs so
    // the answer can be registered on the accepting edge.
    // ------------------------------------------------------------------
    always_comb begin
        alu_y   = '0;
        alu_err = 1'b0;
        is_mul  = 1'b0;
        case (Ctrl)
            OP_ADD:  alu_y = A + B;
            OP_SUB:  alu_y = A - B;
            OP_AND:  alu_y = A & B;
            OP_OR:   alu_y = A | B;
            OP_XOR:  alu_y = A ^ B;
            OP_SLL:  alu_y = A << B[4:0];
            OP_SRL:  alu_y = A >> B[4:0];
`ifdef ALU_SEQ_UNIT_MUL_EN
            OP_MUL:  is_mul = 1'b1;
`endif
            OP_SLT:  alu_y = {31'd0, ($signed(A) < $signed(B))};
            default: alu_err = 1'b1;   // alu_y stays 0, so zero reports 1
        endcase
    end

`ifdef ALU_SEQ_UNIT_MUL_EN
    // ------------------------------------------------------------------
    // Shift-add multiplier: one bit of B per cycle, LSB first. Only the low
    // 32 bits of the product are kept, so the multiplicand can simply shift
    // its upper bits out.
    // ------------------------------------------------------------------
    logic [31:0] mul_acc, mul_mcand, mul_mplier;
    logic [4:0]  mul_cnt;
    logic [31:0] mul_acc_nxt;
    logic        mul_last;

    assign mul_acc_nxt = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
    assign mul_last    = (state == EXEC) && (mul_cnt == 5'd31);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
        end else if (accept && is_mul) begin
            mul_acc    <= '0;
            mul_mcand  <= A;
            mul_mplier <= B;
            mul_cnt    <= '0;
        end else if (state == EXEC) begin
            mul_acc    <= mul_acc_nxt;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt + 5'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = HOLD;
`ifdef ALU_SEQ_UNIT_MUL_EN
                if (in_valid && is_mul) state_nxt = EXEC;
`endif
            end
`ifdef ALU_SEQ_UNIT_MUL_EN
            EXEC: begin
                if (mul_last) state_nxt = HOLD;
            end
`endif
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Result register. Loaded only on acceptance (single-cycle ops) or on
    // the final multiplier step, so it is frozen throughout HOLD.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (accept && !is_mul) begin
            res_q.y    <= alu_y;
            res_q.zero <= (alu_y == 32'd0);
            res_q.err  <= alu_err;
        end
`ifdef ALU_SEQ_UNIT_MUL_EN
        else if (mul_last) begin
            res_q.y    <= mul_acc_nxt;
            res_q.zero <= (mul_acc_nxt == 32'd0);
            res_q.err  <= 1'b0;
        end
`endif
    end

    assign Y    = res_q.y;
    assign zero = res_q.zero;
    assign err  = res_q.err;

endmodule

// File: tb/tb_alu_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_unit
//   Scoreboard bench: the driver pushes the reference-model answer for each
//   accepted request; the monitor pops and compares whenever out_valid is
//   seen, including latency, hold stability under backpressure and the
//   return to IDLE after consumption.
// ---------------------------------------------------------------------------
module tb_alu_seq_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A, B;
    logic [4:0]  Ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Y;
    logic        zero;
    logic        err;

    alu_seq_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Ctrl      (Ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .zero      (zero),
        .err       (err)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  c;
        int          stall;
    } stim_t;

    typedef struct {
        logic [31:0] y;
        logic        z;
        logic        e;
        int          lat;
        int          acc;
        int          stall;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit paused = 1'b1;
    bit gaps   = 1'b0;
    bit first  = 1'b1;
    bit just_consumed = 1'b0;
    int hold_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference model straight from the opcode table.
    function automatic exp_t model(input stim_t s, input int acc);
        exp_t r;
        logic [63:0] p;
        logic [4:0]  sh;
        r.e     = 1'b0;
        r.lat   = 1;
        r.acc   = acc;
        r.stall = s.stall;
        r.y     = 32'd0;
        sh      = s.b[4:0];
        p       = 64'd0;
        case (s.c)
            5'd0: r.y = s.a + s.b;
            5'd1: r.y = s.a - s.b;
            5'd2: r.y = s.a & s.b;
            5'd3: r.y = s.a | s.b;
            5'd4: r.y = s.a ^ s.b;
            5'd5: r.y = s.a << sh;
            5'd6: r.y = s.a >> sh;
            5'd7: begin
`ifdef ALU_SEQ_UNIT_MUL_EN
                p     = {32'd0, s.a} * {32'd0, s.b};
                r.y   = p[31:0];
                r.lat = 32;
`else
                r.e = 1'b1;
`endif
            end
            5'd8: r.y = ($signed(s.a) < $signed(s.b)) ? 32'd1 : 32'd0;
            default: r.e = 1'b1;
        endcase
        r.z = (r.y == 32'd0);
        return r;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [4:0] c, input int stall);
        stim_t s;
        s.a = a; s.b = b; s.c = c; s.stall = stall;
        stim_q.push_back(s);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 5000) begin
            errors++;
            $display("FAIL drain_%s: %0d results outstanding, expected 0", tag, exp_q.size());
        end
        @(posedge clk);
    endtask

    // Driver: offers a queued request whenever the block is idle; while it
    // is busy, throws random junk at the inputs, which must be ignored.
    initial begin
        stim_t s;
        in_valid = 1'b0;
        A = '0; B = '0; Ctrl = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || paused) begin
                in_valid = 1'b0;
            end else if (in_ready) begin
                if (stim_q.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                    s = stim_q.pop_front();
                    in_valid = 1'b1;
                    A = s.a; B = s.b; Ctrl = s.c;
                    exp_q.push_back(model(s, cyc));
                end else begin
                    in_valid = 1'b0;
                    A = $urandom; B = $urandom; Ctrl = 5'($urandom);
                end
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                A = $urandom; B = $urandom; Ctrl = 5'($urandom);
            end
        end
    end

    // Monitor / scoreboard, also owns out_ready.
    initial begin
        exp_t e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (just_consumed && rst_n) begin
                check("idle_after_consume_in_ready", {31'd0, in_ready}, 32'd1);
                check("idle_after_consume_out_valid", {31'd0, out_valid}, 32'd0);
            end
            just_consumed = 1'b0;
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
                    out_ready = 1'b1;
                end else begin
                    e = exp_q[0];
                    if (first) check("latency", cyc - e.acc, e.lat);
                    first = 1'b0;
                    check("Y", Y, e.y);
                    check("zero", {31'd0, zero}, {31'd0, e.z});
                    check("err", {31'd0, err}, {31'd0, e.e});
                    check("in_ready_while_holding", {31'd0, in_ready}, 32'd0);
                    if (hold_cnt >= e.stall) begin
                        out_ready = 1'b1;
                        void'(exp_q.pop_front());
                        first = 1'b1;
                        hold_cnt = 0;
                        just_consumed = 1'b1;
                    end else begin
                        out_ready = 1'b0;
                        hold_cnt++;
                    end
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_Y", Y, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        paused = 1'b0;

        // Basic ops, back to back
        for (int i = 0; i < 7; i++) push(32'd2, 32'd1, 5'(i), 0);
        // Wrap-around and signed compare
        push(32'hFFFF_FFFF, 32'd1, 5'd0, 0);
        push(32'd0,         32'd1, 5'd1, 0);
        push(32'hFFFF_FFFF, 32'd0, 5'd8, 0);
        push(32'd3, 32'hFFFF_FFFF, 5'd8, 0);
        // Multiply (illegal when not built in)
        push(32'd7, 32'd6, 5'd7, 0);
        push(32'h1_0000, 32'h1_0000, 5'd7, 0);
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1);
        // Backpressure for 10 cycles
        push(32'd5, 32'd3, 5'd0, 10);
        // Illegal opcodes
        push(32'd9, 32'd9, 5'd31, 0);
        push(32'd9, 32'd9, 5'd9, 2);
        drain("directed");

        // Reset in the middle of a multiply
        push(32'd7, 32'd6, 5'd7, 0);
        for (int n = 0; n < 100 && stim_q.size() != 0; n++) @(posedge clk);
        repeat (9) @(posedge clk);
        #2;
        paused = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_Y", Y, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        exp_q.delete();
        first = 1'b1;
        hold_cnt = 0;
        just_consumed = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("no_stale_result", {31'd0, out_valid}, 32'd0);
        check("idle_after_reset", {31'd0, in_ready}, 32'd1);
        paused = 1'b0;

        // Randomized traffic
        gaps = 1'b1;
        for (int i = 0; i < 150; i++) begin
            stim_t s;
            s.a = pick_operand();
            s.b = pick_operand();
            s.c = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 8)) : 5'($urandom_range(0, 31));
            s.stall = $urandom_range(0, 3);
            stim_q.push_back(s);
        end
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 The block SHALL have the ports below, each as name, direction, width and meaning.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  operand/opcode request valid.
REQ-005 in_ready  out  1  block can accept a request.
REQ-006 A  in  32  operand A.
REQ-007 B  in  32  operand B.
REQ-008 Ctrl  in  5  opcode.
REQ-009 out_valid  out  1  result valid.
REQ-010 out_ready  in  1  consumer accepts result.
REQ-011 Y  out  32  result.
REQ-012 zero  out  1  Y == 0 for the presented result.
REQ-013 err  out  1  illegal or disabled opcode for the presented result.

Function
REQ-014 The block SHALL implement a state machine with states IDLE, EXEC and HOLD.
REQ-015 in_ready SHALL be 1 only in IDLE; a request is accepted on any edge with in_valid=1 and in_ready=1, and A, B and Ctrl are captured then.
REQ-016 Opcodes SHALL be: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SLL (A<<B[4:0]), 6 SRL logical (A>>B[4:0]), 7 MUL (low 32 bits of A*B, unsigned), 8 SLT signed (Y=1 if $signed(A)<$signed(B), else 0).
REQ-017 ADD, SUB and MUL SHALL wrap modulo 2^32; no carry or overflow output exists.
REQ-018 Opcodes 0-6 and 8 SHALL go IDLE->HOLD, with out_valid=1 on the edge after acceptance (latency 1).
REQ-019 MUL SHALL go IDLE->EXEC and run a shift-add multiplier over exactly 32 iterations, one per cycle, then enter HOLD; out_valid rises 32 cycles after acceptance.
REQ-020 Opcodes 9-31 SHALL go IDLE->HOLD with latency 1, Y=0, zero=1 and err=1.
REQ-021 In HOLD, Y, zero and err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 In HOLD with out_ready=1, the result SHALL be consumed and the block SHALL return to IDLE; at most one request is accepted per two cycles, with no bypass.
REQ-023 in_valid and A, B and Ctrl changes SHALL be ignored outside IDLE.
REQ-024 out_ready SHALL be ignored outside HOLD.
REQ-025 zero SHALL equal (Y==0) whenever out_valid=1.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, in_ready=1, out_valid=0, Y=0, zero=0, err=0, and clear the multiplier accumulator and iteration counter.
REQ-027 Reset in EXEC or HOLD SHALL discard the in-flight operation with no result produced.
REQ-028 The first request SHALL be accepted on the first rising edge after rst_n deasserts with in_valid=1.

Configuration
REQ-029 The macro ALU_SEQ_UNIT_MUL_EN SHALL control the MUL opcode.
REQ-030 With ALU_SEQ_UNIT_MUL_EN defined, opcode 7 SHALL behave per REQ-019.
REQ-031 Without ALU_SEQ_UNIT_MUL_EN, the EXEC state and multiplier logic SHALL be absent, and opcode 7 SHALL be treated as illegal per REQ-020.

Verification
REQ-032 A=2, B=1, Ctrl=0,1,2,3,4,5,6 in sequence with out_ready=1 -> Y=3,1,0,3,3,4,1, err=0, each result one cycle after acceptance.
REQ-033 A=32'hFFFFFFFF, B=1, Ctrl=0 -> Y=0, zero=1; then A=0, B=1, Ctrl=1 -> Y=32'hFFFFFFFF; then A=32'hFFFFFFFF (-1), B=0, Ctrl=8 -> Y=1.
REQ-034 MUL enabled: A=7, B=6, Ctrl=7 -> in_ready=0 for 32 cycles, then Y=42, out_valid=1; A=32'h10000, B=32'h10000 -> Y=0, zero=1.
REQ-035 Backpressure: result of A=5, B=3, Ctrl=0 with out_ready=0 for 10 cycles -> Y=8 held stable, in_ready=0 and new in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-036 Ctrl=31 -> Y=0, err=1; MUL disabled build: Ctrl=7 -> Y=0, err=1 with latency 1.
REQ-037 rst_n pulsed low during cycle 10 of a MUL -> out_valid=0, in_ready=1 immediately; no stale result after release.
